alu_result_skid: RTL and testbench

//  Execute-to-writeback stage directly downstream of the 32-bit adder/subtractor.

---
 rtl/mrisc_pkg.sv | 21 ++
 rtl/wb_entry_reg.sv | 21 ++
 rtl/alu_result_skid.sv | 131 +++++++++++++
 tb/tb_alu_result_skid.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mrisc_pkg.sv
// Shared types for the mrisc execute/writeback path.
// Holds datapath widths, skid FSM states and the writeback entry bundle.
package mrisc_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic [DATA_W-1:0]     result;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wen;
    logic                  trap;
  } wb_entry_t;

endpackage

// File: rtl/wb_entry_reg.sv
// Load-enabled writeback entry register.
// Clears asynchronously to an all-zero entry.
module wb_entry_reg
  import mrisc_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      ld,
  input  wb_entry_t d,
  output wb_entry_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/alu_result_skid.sv
// Execute-to-writeback skid stage behind the adder/subtractor.
// Two-entry valid/ready buffer with overflow trap and sticky flag.
module alu_result_skid
  import mrisc_pkg::*;
#(
  parameter int DATA_W     = mrisc_pkg::DATA_W,
  parameter int REG_ADDR_W = mrisc_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_result,
  input  logic                  in_overflow,
  input  logic                  in_trap_en,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_wen,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_wen,
  output logic                  out_trap,
  output logic                  ovf_sticky,
  input  logic                  ovf_clr
);

  skid_state_t state_q, state_d;
  logic        ready_q, valid_q;
  logic        sticky_q;
  logic        accept, pop;
  logic        head_ld, skid_ld;
  wb_entry_t   new_e, head_d, head_q, skid_q;

  assign accept = in_valid & ready_q;
  assign pop    = valid_q & out_ready;

  // Trapping overflow keeps the result but never reaches the register file.
  always_comb begin
    new_e.result = in_result;
    new_e.rd     = in_rd;
    new_e.trap   = in_overflow & in_trap_en;
    new_e.wen    = in_wen & ~new_e.trap & (in_rd != '0);
  end

  always_comb begin
    state_d = state_q;
    head_ld = 1'b0;
    skid_ld = 1'b0;
    head_d  = new_e;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            head_ld = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_ld = 1'b1;
          end else if (accept) begin
            state_d = TWO;
            skid_ld = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            head_ld = 1'b1;
            head_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != TWO);
      valid_q <= (state_d != EMPTY);
    end
  end

  // A dropped (flushed) input must not mark overflow; set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (accept && !flush && in_overflow) begin
      sticky_q <= 1'b1;
    end else if (ovf_clr) begin
      sticky_q <= 1'b0;
    end
  end

  wb_entry_reg u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (head_ld),
    .d     (head_d),
    .q     (head_q)
  );

  wb_entry_reg u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (skid_ld),
    .d     (new_e),
    .q     (skid_q)
  );

  assign in_ready   = ready_q;
  assign out_valid  = valid_q;
  assign out_result = head_q.result;
  assign out_rd     = head_q.rd;
  assign out_wen    = head_q.wen;
  assign out_trap   = head_q.trap;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_alu_result_skid.sv
// Directed self-checking bench for alu_result_skid.
module tb_alu_result_skid;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_overflow;
  logic        in_trap_en;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_trap;
  logic        ovf_sticky;
  logic        ovf_clr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_result_skid dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_overflow (in_overflow),
    .in_trap_en  (in_trap_en),
    .in_rd       (in_rd),
    .in_wen      (in_wen),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_wen     (out_wen),
    .out_trap    (out_trap),
    .ovf_sticky  (ovf_sticky),
    .ovf_clr     (ovf_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r,
                       input logic [4:0] rd, input logic w,
                       input logic ov, input logic te);
    in_valid    = v;
    in_result   = r;
    in_rd       = rd;
    in_wen      = w;
    in_overflow = ov;
    in_trap_en  = te;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    ovf_clr = 1'b0;
    idle();
    #12;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_result", out_result, 32'd0);
    chk("rst_rd", {27'b0, out_rd}, 32'd0);
    chk("rst_wen", {31'b0, out_wen}, 32'd0);
    chk("rst_trap", {31'b0, out_trap}, 32'd0);
    chk("rst_sticky", {31'b0, ovf_sticky}, 32'd0);

    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h5, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    chk("first_valid", {31'b0, out_valid}, 32'd1);
    chk("first_result", out_result, 32'h5);
    chk("first_rd", {27'b0, out_rd}, 32'd3);
    chk("first_wen", {31'b0, out_wen}, 32'd1);
    idle();
    tick();
    chk("first_drain", {31'b0, out_valid}, 32'd0);

    out_ready = 1'b0;
    drive(1'b1, 32'h11, 5'd1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("a_ready", {31'b0, in_ready}, 32'd1);
    chk("a_head", out_result, 32'h11);
    drive(1'b1, 32'h22, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    chk("b_ready", {31'b0, in_ready}, 32'd0);
    chk("b_head", out_result, 32'h11);
    drive(1'b1, 32'h99, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    chk("hold_result", out_result, 32'h11);
    chk("hold_rd", {27'b0, out_rd}, 32'd1);
    idle();
    out_ready = 1'b1;
    tick();
    chk("pop_a_result", out_result, 32'h22);
    chk("pop_a_rd", {27'b0, out_rd}, 32'd2);
    chk("pop_a_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("pop_b_valid", {31'b0, out_valid}, 32'd0);

    drive(1'b1, 32'h8000_0000, 5'd7, 1'b1, 1'b1, 1'b1);
    tick();
    chk("trap_trap", {31'b0, out_trap}, 32'd1);
    chk("trap_wen", {31'b0, out_wen}, 32'd0);
    chk("trap_result", out_result, 32'h8000_0000);
    chk("trap_sticky", {31'b0, ovf_sticky}, 32'd1);
    idle();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_sticky", {31'b0, ovf_sticky}, 32'd0);

    drive(1'b1, 32'h1234, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("rd0_wen", {31'b0, out_wen}, 32'd0);
    chk("rd0_valid", {31'b0, out_valid}, 32'd1);
    drive(1'b1, 32'hffff_0000, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    chk("uovf_wen", {31'b0, out_wen}, 32'd1);
    chk("uovf_trap", {31'b0, out_trap}, 32'd0);
    chk("uovf_sticky", {31'b0, ovf_sticky}, 32'd1);
    idle();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr2_sticky", {31'b0, ovf_sticky}, 32'd0);

    out_ready = 1'b0;
    drive(1'b1, 32'h33, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h44, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    chk("two_ready", {31'b0, in_ready}, 32'd0);
    drive(1'b1, 32'h55, 5'd5, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush2_valid", {31'b0, out_valid}, 32'd0);
    chk("flush2_ready", {31'b0, in_ready}, 32'd1);
    idle();
    tick();
    chk("flush2_gone", {31'b0, out_valid}, 32'd0);

    drive(1'b1, 32'h66, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h77, 5'd7, 1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush1_valid", {31'b0, out_valid}, 32'd0);
    chk("flush1_sticky", {31'b0, ovf_sticky}, 32'd0);
    idle();
    tick();
    chk("flush1_gone", {31'b0, out_valid}, 32'd0);

    out_ready = 1'b1;
    drive(1'b1, 32'h88, 5'd8, 1'b1, 1'b1, 1'b0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("setwins_sticky", {31'b0, ovf_sticky}, 32'd1);
    chk("setwins_result", out_result, 32'h88);

    out_ready = 1'b0;
    drive(1'b1, 32'haa, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hbb, 5'd11, 1'b1, 1'b0, 1'b0);
    tick();
    chk("pre_rst_ready", {31'b0, in_ready}, 32'd0);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_result", out_result, 32'd0);
    chk("arst_rd", {27'b0, out_rd}, 32'd0);
    chk("arst_wen", {31'b0, out_wen}, 32'd0);
    chk("arst_sticky", {31'b0, ovf_sticky}, 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("arst_nodrain", {31'b0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
